patron_sequencer: RTL and testbench
===================================

PATRON_SEQUENCER -- requirements
Module: patron_sequencer

Interface
REQ-001 Parameter SCROLL_STEP, default 12'sd1: signed scroll increment applied per frame tick.
REQ-002 Parameter START_DELAY, default 120: frames held at position 0 before scrolling starts.
REQ-003 Parameter LIST_LEN, default 1024: scroll position (unsigned magnitude) at which scrolling ends.
REQ-004 Parameter HOLD_FRAMES, default 60: frames held at the end position.
REQ-005 Parameter LOOP, default 1'b0: 1 means restart from DELAY after HOLD instead of returning to IDLE.
REQ-006 clk_sys  in  1  master video clock, the same clock that drives the video pipeline.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 VSync  in  1  core vertical sync, active low, asynchronous to clk_sys.
REQ-009 start  in  1  level request to show the patrons list.
REQ-010 abort  in  1  level request to stop immediately.
REQ-011 pause  in  1  freezes all frame counters and the scroll position.
REQ-012 patrons  out  1  patron overlay enable for the video pipeline.
REQ-013 scroll_pos  out  12 signed  overlay offset, added by the pipeline to the X or Y adjust.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on a normal (non-abort) return to IDLE.

Function
REQ-016 The block SHALL synchronise VSync through a 2-flop chain and generate frame_tick for one clk_sys cycle on each synchronised falling edge.
REQ-017 The block SHALL implement the states IDLE, DELAY, SCROLL and HOLD, with a 2-bit encoding.
REQ-018 IDLE: a rising edge of start SHALL move the block to DELAY and clear frame_cnt and scroll_pos to 0; a start level held high SHALL NOT retrigger the block.
REQ-019 DELAY: frame_cnt SHALL increment on each frame_tick; when frame_cnt equals START_DELAY-1 on a tick, the block SHALL move to SCROLL and clear frame_cnt.
REQ-020 SCROLL: scroll_pos SHALL increase by SCROLL_STEP on each frame_tick.
REQ-021 SCROLL exit: when |scroll_pos+SCROLL_STEP| >= LIST_LEN, scroll_pos SHALL saturate to ±LIST_LEN (sign of SCROLL_STEP) and the block SHALL move to HOLD; the register SHALL never wrap.
REQ-022 HOLD: frame_cnt SHALL count to HOLD_FRAMES-1; on that tick the block SHALL go to IDLE with done=1, or to DELAY with scroll_pos=0 if LOOP=1 (no done pulse).
REQ-023 START_DELAY=0 or HOLD_FRAMES=0 SHALL skip the corresponding state on the next frame_tick.
REQ-024 abort high SHALL force IDLE on the next clock from any state, clear scroll_pos and frame_cnt, and produce no done pulse; abort takes priority over start, pause and frame_tick.
REQ-025 pause high SHALL block frame_tick effects only; the state and outputs are otherwise held and abort remains effective.
REQ-026 patrons SHALL be 1 in DELAY, SCROLL and HOLD and 0 in IDLE.
REQ-027 All outputs SHALL be registered, and scroll_pos SHALL change at most once per frame.
REQ-028 A start rising edge while busy SHALL be ignored.

Reset
REQ-029 While reset_n=0: state=IDLE, scroll_pos=0, frame_cnt=0, patrons=0, busy=0, done=0, and the sync chain is set to 1 (inactive).
REQ-030 Reset mid-sequence SHALL abandon the sequence with no done pulse; after release the block SHALL wait for a new start rising edge.

Structure
REQ-031 The state encoding and the default timing constants SHALL live in the shared package video_pkg.
REQ-032 The synchroniser plus falling-edge detector SHALL be the single sub-module vsync_tick.
REQ-033 frame_cnt SHALL be wide enough for max(START_DELAY, HOLD_FRAMES); scroll arithmetic SHALL be 13-bit signed internally to detect overflow.

Verification
REQ-034 START_DELAY=2, STEP=4, LIST_LEN=16, HOLD=2; start pulse then 10 VSync falls -> patrons rises 1 clk after start; scroll_pos runs 0,0,4,8,12,16,16; then IDLE with done=1 for one cycle.
REQ-035 STEP=-5, LIST_LEN=12 -> scroll_pos goes 0,-5,-10,-12 (saturated) and HOLD is entered.
REQ-036 abort asserted in the same cycle as frame_tick during SCROLL (scroll_pos=8) -> next clock IDLE, scroll_pos=0, done stays 0.
REQ-037 pause held for 5 VSync falls during SCROLL -> scroll_pos unchanged; after release it increments on the next tick.
REQ-038 LOOP=1 -> after HOLD, DELAY is re-entered with scroll_pos=0 and no done pulse; start held high throughout causes no extra restart.
REQ-039 reset_n pulled low during HOLD -> all outputs 0 asynchronously; after release the block stays IDLE until a start rising edge.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video definitions: sequencer state encoding and default timing constants.
package video_pkg;

    // Patron overlay sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_SCROLL = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_t;

    // Default timing of the patrons list (in frames / pixels)
    localparam logic signed [11:0] DEF_SCROLL_STEP = 12'sd1;
    localparam int                 DEF_START_DELAY = 120;
    localparam int                 DEF_LIST_LEN    = 1024;
    localparam int                 DEF_HOLD_FRAMES = 60;

    // Width of a counter that must hold the larger of two frame counts
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = 1;
        while ((1 << w) <= m) w++;
        return w;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// VSync synchroniser and falling-edge detector producing a one-cycle frame tick.
module vsync_tick (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic VSync,
    output logic frame_tick
);

    logic vs_p0;
    logic vs_p1;
    logic vs_p2;

    // Two-flop synchroniser plus one history flop; all preset to the inactive (high) level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vs_p0 <= 1'b1;
            vs_p1 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            vs_p0 <= VSync;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
        end
    end

    // Falling edge of the synchronised VSync, decoded from flop outputs only
    assign frame_tick = vs_p2 & ~vs_p1;

endmodule

// File: rtl/patron_sequencer.sv
// Patron list sequencer: delay, scroll and hold the patrons overlay, frame by frame.
module patron_sequencer
    import video_pkg::*;
#(
    parameter logic signed [11:0] SCROLL_STEP = DEF_SCROLL_STEP,
    parameter int                 START_DELAY = DEF_START_DELAY,
    parameter int                 LIST_LEN    = DEF_LIST_LEN,
    parameter int                 HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter logic               LOOP        = 1'b0
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                VSync,
    input  logic                start,
    input  logic                abort,
    input  logic                pause,
    output logic                patrons,
    output logic signed [11:0]  scroll_pos,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = cnt_width(START_DELAY, HOLD_FRAMES);

    // Scroll arithmetic runs one bit wider so the end test cannot be fooled by a wrap
    localparam logic signed [12:0] STEP_X  = {SCROLL_STEP[11], SCROLL_STEP};
    localparam logic signed [12:0] LIMIT_X = 13'(LIST_LEN);
    localparam logic signed [11:0] END_POS = (SCROLL_STEP < 0) ? -12'(LIST_LEN) : 12'(LIST_LEN);

    seq_state_t              state;
    seq_state_t              state_nxt;
    logic [CNT_W-1:0]        frame_cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic signed [11:0]      pos_nxt;
    logic signed [12:0]      pos_sum;
    logic                    done_nxt;
    logic                    start_p0;
    logic                    start_rise;
    logic                    frame_tick;
    logic                    tick_en;
    logic                    delay_last;
    logic                    hold_last;

    function automatic logic signed [12:0] abs_x(input logic signed [12:0] v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic reached_end(input logic signed [12:0] sum);
        return abs_x(sum) >= LIMIT_X;
    endfunction

    // Clamp the next position to the list end, keeping the sign of the step
    function automatic logic signed [11:0] sat_pos(input logic signed [12:0] sum);
        return reached_end(sum) ? END_POS : $signed(sum[11:0]);
    endfunction

    vsync_tick u_vsync_tick (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .VSync      (VSync),
        .frame_tick (frame_tick)
    );

    assign start_rise = start & ~start_p0;
    assign tick_en    = frame_tick & ~pause;
    assign pos_sum    = $signed({scroll_pos[11], scroll_pos}) + STEP_X;
    // A zero-length phase compares against -1, so it ends on the very next tick
    assign delay_last = int'(frame_cnt) >= START_DELAY - 1;
    assign hold_last  = int'(frame_cnt) >= HOLD_FRAMES - 1;

    // Next-state, frame counter, scroll position and done decode; abort overrides everything
    always_comb begin
        state_nxt = state;
        cnt_nxt   = frame_cnt;
        pos_nxt   = scroll_pos;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            pos_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_nxt = ST_DELAY;
                        cnt_nxt   = '0;
                        pos_nxt   = '0;
                    end
                end
                ST_DELAY: begin
                    if (tick_en) begin
                        if (delay_last) begin
                            state_nxt = ST_SCROLL;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = frame_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SCROLL: begin
                    if (tick_en) begin
                        pos_nxt = sat_pos(pos_sum);
                        if (reached_end(pos_sum)) begin
                            state_nxt = ST_HOLD;
                            cnt_nxt   = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_en) begin
                        if (hold_last) begin
                            cnt_nxt = '0;
                            if (LOOP) begin
                                state_nxt = ST_DELAY;
                                pos_nxt   = '0;
                            end else begin
                                state_nxt = ST_IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            cnt_nxt = frame_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // State and output registers; start history presets high so a level held through reset is not an edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            scroll_pos <= '0;
            patrons    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_p0   <= 1'b1;
        end else begin
            state      <= state_nxt;
            frame_cnt  <= cnt_nxt;
            scroll_pos <= pos_nxt;
            patrons    <= (state_nxt != ST_IDLE);
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            start_p0   <= start;
        end
    end

endmodule

// File: tb/tb_patron_sequencer.sv
// Self-checking bench for patron_sequencer: three parameterisations driven in lockstep.
module tb_patron_sequencer;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic VSync   = 1'b1;
    logic start   = 1'b0;
    logic abort   = 1'b0;
    logic pause   = 1'b0;

    logic              patrons_a, busy_a, done_a;
    logic              patrons_b, busy_b, done_b;
    logic              patrons_c, busy_c, done_c;
    logic signed [11:0] pos_a, pos_b, pos_c;

    int n_done_a = 0;
    int n_done_b = 0;
    int n_done_c = 0;
    int checks   = 0;
    int errors   = 0;

    typedef struct {
        int pos_a;
        int busy_a;
        int pos_b;
        int busy_b;
        int pos_c;
        int busy_c;
    } row_t;

    row_t rows [11];

    always #5 clk_sys = ~clk_sys;

    // A: step +4 to 16, B: step -5 to 12, C: as A but looping
    patron_sequencer #(.SCROLL_STEP(12'sd4), .START_DELAY(2), .LIST_LEN(16), .HOLD_FRAMES(2), .LOOP(1'b0)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .VSync(VSync), .start(start), .abort(abort), .pause(pause),
        .patrons(patrons_a), .scroll_pos(pos_a), .busy(busy_a), .done(done_a));

    patron_sequencer #(.SCROLL_STEP(-12'sd5), .START_DELAY(2), .LIST_LEN(12), .HOLD_FRAMES(2), .LOOP(1'b0)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .VSync(VSync), .start(start), .abort(abort), .pause(pause),
        .patrons(patrons_b), .scroll_pos(pos_b), .busy(busy_b), .done(done_b));

    patron_sequencer #(.SCROLL_STEP(12'sd4), .START_DELAY(2), .LIST_LEN(16), .HOLD_FRAMES(2), .LOOP(1'b1)) dut_c (
        .clk_sys(clk_sys), .reset_n(reset_n), .VSync(VSync), .start(start), .abort(abort), .pause(pause),
        .patrons(patrons_c), .scroll_pos(pos_c), .busy(busy_c), .done(done_c));

    always @(posedge clk_sys) begin
        if (done_a) n_done_a <= n_done_a + 1;
        if (done_b) n_done_b <= n_done_b + 1;
        if (done_c) n_done_c <= n_done_c + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic vsync_fall();
        @(negedge clk_sys) VSync = 1'b0;
        repeat (5) @(negedge clk_sys);
        VSync = 1'b1;
        repeat (5) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        start   = 1'b0;
        abort   = 1'b0;
        pause   = 1'b0;
        VSync   = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic start_pulse();
        @(negedge clk_sys) start = 1'b1;
        @(negedge clk_sys) start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int da, db, dc;

        // Expected state after each VSync fall with start held high after the first edge
        rows[0]  = '{0, 1,   0, 1, 0, 1};
        rows[1]  = '{0, 1,   0, 1, 0, 1};
        rows[2]  = '{4, 1,  -5, 1, 4, 1};
        rows[3]  = '{8, 1, -10, 1, 8, 1};
        rows[4]  = '{12, 1, -12, 1, 12, 1};
        rows[5]  = '{16, 1, -12, 1, 16, 1};
        rows[6]  = '{16, 1, -12, 0, 16, 1};
        rows[7]  = '{16, 0, -12, 0, 0, 1};
        rows[8]  = '{16, 0, -12, 0, 0, 1};
        rows[9]  = '{16, 0, -12, 0, 0, 1};
        rows[10] = '{16, 0, -12, 0, 4, 1};

        // Reset state
        repeat (2) @(negedge clk_sys);
        chk("reset_patrons", patrons_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_pos", pos_a, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Main sequence: start edge, then start held high through the whole run
        start = 1'b1;
        chk("patrons_before_edge", patrons_a, 0);
        @(posedge clk_sys); #1;
        chk("patrons_one_clk", patrons_a, 1);
        chk("busy_one_clk", busy_a, 1);
        chk("pos_start", pos_a, 0);
        da = n_done_a; db = n_done_b; dc = n_done_c;
        for (int i = 0; i < 11; i++) begin
            vsync_fall();
            chk($sformatf("row%0d_pos_a", i), pos_a, rows[i].pos_a);
            chk($sformatf("row%0d_busy_a", i), busy_a, rows[i].busy_a);
            chk($sformatf("row%0d_patrons_a", i), patrons_a, rows[i].busy_a);
            chk($sformatf("row%0d_pos_b", i), pos_b, rows[i].pos_b);
            chk($sformatf("row%0d_busy_b", i), busy_b, rows[i].busy_b);
            chk($sformatf("row%0d_pos_c", i), pos_c, rows[i].pos_c);
            chk($sformatf("row%0d_busy_c", i), busy_c, rows[i].busy_c);
        end
        chk("done_count_a", n_done_a - da, 1);
        chk("done_count_b", n_done_b - db, 1);
        chk("done_count_c_loop", n_done_c - dc, 0);

        // Abort coinciding with a frame tick while scrolling at 8
        do_reset();
        start_pulse();
        repeat (4) vsync_fall();
        chk("abort_pre_pos", pos_a, 8);
        da = n_done_a;
        @(negedge clk_sys) VSync = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        abort = 1'b1;
        @(posedge clk_sys); #1;
        chk("abort_pos_a", pos_a, 0);
        chk("abort_busy_a", busy_a, 0);
        chk("abort_patrons_a", patrons_a, 0);
        chk("abort_pos_b", pos_b, 0);
        abort = 1'b0;
        repeat (4) @(negedge clk_sys);
        VSync = 1'b1;
        vsync_fall();
        chk("abort_stays_idle", busy_a, 0);
        chk("abort_no_done", n_done_a - da, 0);

        // Pause holds the scroll position across five frames
        do_reset();
        start_pulse();
        repeat (3) vsync_fall();
        chk("pause_pre_pos", pos_a, 4);
        pause = 1'b1;
        repeat (5) vsync_fall();
        chk("pause_pos", pos_a, 4);
        chk("pause_busy", busy_a, 1);
        chk("pause_pos_b", pos_b, -5);
        pause = 1'b0;
        vsync_fall();
        chk("pause_release_pos", pos_a, 8);

        // Reset asserted during HOLD, with start held high across release
        do_reset();
        @(negedge clk_sys) start = 1'b1;
        repeat (6) vsync_fall();
        chk("hold_pos", pos_a, 16);
        da = n_done_a; db = n_done_b;
        @(posedge clk_sys); #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_patrons", patrons_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_pos", pos_a, 0);
        chk("async_rst_pos_b", pos_b, 0);
        @(negedge clk_sys) reset_n = 1'b1;
        repeat (3) vsync_fall();
        chk("post_rst_idle", busy_a, 0);
        chk("post_rst_patrons", patrons_a, 0);
        chk("post_rst_no_done_a", n_done_a - da, 0);
        chk("post_rst_no_done_b", n_done_b - db, 0);
        @(negedge clk_sys) start = 1'b0;
        @(negedge clk_sys) start = 1'b1;
        @(posedge clk_sys); #1;
        chk("post_rst_restart", busy_a, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
